paint_port_sched: RTL and testbench
===================================

Name: paint_port_sched

Overview:
- Shares the single framebuffer write port among the paint engines: clear-screen engine (req 0), brush stroke engine (req 1) and cursor drawer (req 2).
- Each engine uses the same init/done/paint/x/y/px_data handshake.
- The block picks one pending requester round-robin, issues its one-cycle init pulse and forwards its pixel writes to the framebuffer.
- Ownership is released on the engine's done pulse, or forced away by a watchdog timeout.

Parameters:
- N_REQ, 3, number of requesting engines (index 0 = clear, 1 = brush, 2 = cursor).
- COORD_W, 6, x/y coordinate width (64x64 canvas).
- DATA_W, 8, pixel data width.
- TIMEOUT, 8192, maximum cycles a grant may stay in RUN before a forced abort (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  N_REQ  level request per engine; held by the engine until it is served.
- init_o  out  N_REQ  one-hot, one-cycle start pulse to the granted engine.
- done_i  in  N_REQ  per-engine completion pulse.
- paint_i  in  N_REQ  per-engine pixel write strobe.
- x_i  in  N_REQ*COORD_W  packed x coordinates, engine k at bits [k*COORD_W +: COORD_W].
- y_i  in  N_REQ*COORD_W  packed y coordinates, same packing.
- data_i  in  N_REQ*DATA_W  packed pixel data.
- fb_we  out  1  framebuffer write enable.
- fb_x  out  COORD_W  framebuffer write x.
- fb_y  out  COORD_W  framebuffer write y.
- fb_data  out  DATA_W  framebuffer write data.
- grant  out  N_REQ  one-hot current owner; all zero when no engine owns the port.
- busy  out  1  high in LAUNCH, RUN, RELEASE and ABORT.
- timeout_err  out  1  one-cycle pulse when a grant is aborted.

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; rr pointer=0; watchdog=0.
- IDLE:
  - If any req bit is set, select the first set bit searching from the rr pointer upward, with wrap-around.
  - Latch the selection into grant and go to LAUNCH.
  - With no req, stay in IDLE.
- LAUNCH (1 cycle):
  - init_o = grant.
  - Watchdog cleared.
  - done_i[g] sampled; if high, go to RELEASE, else go to RUN.
- RUN:
  - Watchdog increments each cycle.
  - done_i[g]=1 -> RELEASE.
  - Otherwise, if watchdog == TIMEOUT-1 -> ABORT.
  - If done and timeout occur in the same cycle, done wins and there is no error.
- RELEASE (1 cycle):
  - rr pointer = (g+1) mod N_REQ.
  - grant is cleared on exit.
  - Next state is IDLE.
- ABORT (1 cycle):
  - timeout_err=1.
  - rr pointer advances as in RELEASE.
  - Next state is IDLE.
- Forwarding:
  - Registered, latency 1 cycle.
  - When state is LAUNCH or RUN: fb_we <= paint_i[g], and fb_x/fb_y/fb_data <= slice g.
  - In all other states fb_we <= 0 and the address/data outputs hold their last value.
- Ignored inputs:
  - paint_i and done_i from non-granted engines are ignored.
  - req deassertion during LAUNCH or RUN is ignored; only done or timeout ends a grant.
- Throughput:
  - Minimum grant-to-grant spacing is 3 cycles (done sampled -> RELEASE -> IDLE -> LAUNCH).
  - A requester that still holds req after its own done is served again only after every other pending requester.
- Reset mid-grant: the grant is dropped immediately, no init/fb_we glitch is produced, and the pointer returns to 0.
- Watchdog width: clog2(TIMEOUT). The watchdog saturates; it never wraps.

Decomposition:
- Shared package paint_sched_pkg holds:
  - the state enum {IDLE, LAUNCH, RUN, RELEASE, ABORT};
  - default N_REQ/COORD_W/DATA_W constants;
  - requester index constants REQ_CLEAR=0, REQ_BRUSH=1, REQ_CURSOR=2.
- Sub-module rr_pick: combinational round-robin selector taking req and pointer, returning a one-hot pick and a valid flag.
- FSM, watchdog and forwarding mux stay in the top block.

Test Plan:
- Single request: req=3'b100 from reset -> grant=3'b100 and init_o[2] pulse in cycle 2. The engine then paints 4 pixels at (10,20) with data 0xFF; each appears on fb_* one cycle later with fb_we=1. done -> busy low 2 cycles later.
- Contention fairness: req=3'b111 held with each engine finishing after 5 cycles -> grant order 0,1,2,0 (pointer wraps) and no engine is granted twice in a row.
- Isolation: while engine 1 owns the port, engine 0 toggles paint_i[0] and pulses done_i[0] -> fb_we tracks only paint_i[1] and the grant is not released.
- Timeout: TIMEOUT=16, engine never asserts done -> ABORT after exactly 16 RUN cycles, timeout_err pulses once, and the next pending requester is granted.
- Done/timeout race: done_i[g] asserted in the cycle watchdog==TIMEOUT-1 -> RELEASE taken and timeout_err stays 0.
- Async reset mid-RUN: rst asserted between clock edges -> grant, init_o, fb_we and busy all 0 immediately. After release, req=3'b110 grants engine 1 first, since the pointer is back at 0.

Source files
------------

// File: rtl/paint_sched_pkg.sv
// rtl/paint_sched_pkg.sv - shared types and constants for the paint port scheduler
package paint_sched_pkg;

   localparam int N_REQ_DEF   = 3;
   localparam int COORD_W_DEF = 6;
   localparam int DATA_W_DEF  = 8;
   localparam int TIMEOUT_DEF = 8192;

   localparam int REQ_CLEAR  = 0;
   localparam int REQ_BRUSH  = 1;
   localparam int REQ_CURSOR = 2;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      RUN,
      RELEASE,
      ABORT
   } sched_state_t;

endpackage

// File: rtl/paint_port_sched_if.sv
// rtl/paint_port_sched_if.sv - engine handshake and framebuffer write bundle
interface paint_port_sched_if
   import paint_sched_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int COORD_W = COORD_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
);
   logic [N_REQ-1:0]         req;
   logic [N_REQ-1:0]         init_o;
   logic [N_REQ-1:0]         done_i;
   logic [N_REQ-1:0]         paint_i;
   logic [N_REQ*COORD_W-1:0] x_i;
   logic [N_REQ*COORD_W-1:0] y_i;
   logic [N_REQ*DATA_W-1:0]  data_i;
   logic                     fb_we;
   logic [COORD_W-1:0]       fb_x;
   logic [COORD_W-1:0]       fb_y;
   logic [DATA_W-1:0]        fb_data;
   logic [N_REQ-1:0]         grant;
   logic                     busy;
   logic                     timeout_err;

   modport slave (
      input  req, done_i, paint_i, x_i, y_i, data_i,
      output init_o, fb_we, fb_x, fb_y, fb_data, grant, busy, timeout_err
   );

   modport master (
      output req, done_i, paint_i, x_i, y_i, data_i,
      input  init_o, fb_we, fb_x, fb_y, fb_data, grant, busy, timeout_err
   );

endinterface

// File: rtl/paint_port_sched_rr_pick.sv
// rtl/paint_port_sched_rr_pick.sv - combinational round-robin selector
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] pick,
   output logic             valid
);

   // Outer loop walks the search order starting at ptr; first hit wins.
   always_comb begin
      pick  = '0;
      valid = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!valid && req[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
               pick[i] = 1'b1;
               valid   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/paint_port_sched.sv
// rtl/paint_port_sched.sv - shares the framebuffer write port among paint engines
// with round-robin grants, done-based release and a watchdog abort.
module paint_port_sched
   import paint_sched_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int COORD_W = COORD_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic               clk,
   input logic               rst,
   paint_port_sched_if.slave bus
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   sched_state_t       state;
   logic [N_REQ-1:0]   grant_q;
   logic [N_REQ-1:0]   init_q;
   logic [PTR_W-1:0]   g_idx;
   logic [PTR_W-1:0]   rr_ptr;
   logic [WD_W-1:0]    wd;
   logic               busy_q;
   logic               terr_q;
   logic               fb_we_q;
   logic [COORD_W-1:0] fb_x_q;
   logic [COORD_W-1:0] fb_y_q;
   logic [DATA_W-1:0]  fb_data_q;

   logic [N_REQ-1:0]   pick;
   logic               pick_valid;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   next_ptr;
   logic               sel_done;
   logic               sel_paint;
   logic [COORD_W-1:0] sel_x;
   logic [COORD_W-1:0] sel_y;
   logic [DATA_W-1:0]  sel_data;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (bus.req),
      .ptr   (rr_ptr),
      .pick  (pick),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) begin
            pick_idx = PTR_W'(i);
         end
      end
   end

   // Only the owner's strobes and coordinates ever reach the framebuffer.
   always_comb begin
      sel_done  = 1'b0;
      sel_paint = 1'b0;
      sel_x     = '0;
      sel_y     = '0;
      sel_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (g_idx == PTR_W'(i)) begin
            sel_done  = bus.done_i[i];
            sel_paint = bus.paint_i[i];
            sel_x     = bus.x_i[i*COORD_W +: COORD_W];
            sel_y     = bus.y_i[i*COORD_W +: COORD_W];
            sel_data  = bus.data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign next_ptr = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant_q   <= '0;
         init_q    <= '0;
         g_idx     <= '0;
         rr_ptr    <= '0;
         wd        <= '0;
         busy_q    <= 1'b0;
         terr_q    <= 1'b0;
         fb_we_q   <= 1'b0;
         fb_x_q    <= '0;
         fb_y_q    <= '0;
         fb_data_q <= '0;
      end else begin
         init_q  <= '0;
         terr_q  <= 1'b0;
         fb_we_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_q <= pick;
                  init_q  <= pick;
                  g_idx   <= pick_idx;
                  busy_q  <= 1'b1;
                  state   <= LAUNCH;
               end
            end
            LAUNCH: begin
               wd        <= '0;
               fb_we_q   <= sel_paint;
               fb_x_q    <= sel_x;
               fb_y_q    <= sel_y;
               fb_data_q <= sel_data;
               state     <= sel_done ? RELEASE : RUN;
            end
            RUN: begin
               fb_we_q   <= sel_paint;
               fb_x_q    <= sel_x;
               fb_y_q    <= sel_y;
               fb_data_q <= sel_data;
               // Saturate so a stuck watchdog can never wrap back to a legal count.
               if (wd != WD_MAX) begin
                  wd <= wd + 1'b1;
               end
               if (sel_done) begin
                  state <= RELEASE;
               end else if (wd == WD_MAX) begin
                  terr_q <= 1'b1;
                  state  <= ABORT;
               end
            end
            RELEASE, ABORT: begin
               rr_ptr  <= next_ptr;
               grant_q <= '0;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.init_o      = init_q;
   assign bus.grant       = grant_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = terr_q;
   assign bus.fb_we       = fb_we_q;
   assign bus.fb_x        = fb_x_q;
   assign bus.fb_y        = fb_y_q;
   assign bus.fb_data     = fb_data_q;

endmodule

// File: tb/tb_paint_port_sched.sv
// tb/tb_paint_port_sched.sv - self-checking bench for paint_port_sched
module tb_paint_port_sched;

   localparam int NR  = 3;
   localparam int CW  = 6;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   ptr_m;
   logic [CW-1:0] last_x;
   logic [CW-1:0] last_y;
   logic [DW-1:0] last_d;

   paint_port_sched_if #(.N_REQ(NR), .COORD_W(CW), .DATA_W(DW)) bus ();

   paint_port_sched #(
      .N_REQ   (NR),
      .COORD_W (CW),
      .DATA_W  (DW),
      .TIMEOUT (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         if (r[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   task automatic wait_launch(input int exp_g);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (bus.init_o == '0 && n < 8);
      chk("launch_latency", n, 1);
      chk("launch_grant", bus.grant, 32'(1) << exp_g);
      chk("launch_init", bus.init_o, 32'(1) << exp_g);
      chk("launch_busy", bus.busy, 1);
      chk("launch_fb_we", bus.fb_we, 0);
      chk("launch_terr", bus.timeout_err, 0);
   endtask

   // done_at: cycle index counted from LAUNCH (0) at which the owner pulses done; -1 = never.
   task automatic grant_cycle(input int g, input int done_at, input bit directed);
      bit ended;
      logic ew;
      ended = 1'b0;
      for (int c = 0; c <= TMO && !ended; c++) begin
         if (directed) begin
            bus.paint_i = (c < 4) ? NR'(1 << g) : '0;
            bus.done_i  = '0;
            bus.x_i     = {NR{6'd10}};
            bus.y_i     = {NR{6'd20}};
            bus.data_i  = {NR{8'hFF}};
         end else begin
            bus.paint_i = NR'($urandom);
            bus.done_i  = NR'($urandom);
            bus.x_i     = (NR*CW)'($urandom);
            bus.y_i     = (NR*CW)'($urandom);
            bus.data_i  = (NR*DW)'($urandom);
         end
         bus.done_i[g] = (c == done_at);
         ew     = bus.paint_i[g];
         last_x = bus.x_i[g*CW +: CW];
         last_y = bus.y_i[g*CW +: CW];
         last_d = bus.data_i[g*DW +: DW];
         step();
         chk("fwd_we", bus.fb_we, ew);
         chk("fwd_x", bus.fb_x, last_x);
         chk("fwd_y", bus.fb_y, last_y);
         chk("fwd_data", bus.fb_data, last_d);
         chk("run_init_low", bus.init_o, 0);
         chk("run_busy", bus.busy, 1);
         chk("run_grant_held", bus.grant, 32'(1) << g);
         if (c == done_at) begin
            chk("release_terr", bus.timeout_err, 0);
            ended = 1'b1;
         end else if (c == TMO) begin
            chk("abort_terr", bus.timeout_err, 1);
            ended = 1'b1;
         end else begin
            chk("run_terr", bus.timeout_err, 0);
         end
      end
      bus.paint_i = '0;
      bus.done_i  = '0;
      step();
      chk("idle_grant", bus.grant, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_terr", bus.timeout_err, 0);
      chk("idle_fb_we", bus.fb_we, 0);
      chk("hold_x", bus.fb_x, last_x);
      chk("hold_y", bus.fb_y, last_y);
      chk("hold_data", bus.fb_data, last_d);
      ptr_m = (g + 1) % NR;
   endtask

   initial begin
      int e;
      int da;
      logic [NR-1:0] rq;
      total   = 0;
      bad     = 0;
      ptr_m   = 0;
      last_x  = '0;
      last_y  = '0;
      last_d  = '0;
      rst     = 1'b1;
      bus.req = '0;
      bus.done_i  = '0;
      bus.paint_i = '0;
      bus.x_i     = '0;
      bus.y_i     = '0;
      bus.data_i  = '0;

      // reset state
      step();
      step();
      chk("rst_grant", bus.grant, 0);
      chk("rst_init", bus.init_o, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_fb_we", bus.fb_we, 0);
      chk("rst_fb_x", bus.fb_x, 0);
      chk("rst_terr", bus.timeout_err, 0);
      rst = 1'b0;
      step();
      chk("idle_no_req", bus.busy, 0);

      // single request, directed pixels at (10,20)=FF
      bus.req = 3'b100;
      wait_launch(2);
      bus.req = '0;
      grant_cycle(2, 4, 1'b1);

      // fairness with all three holding req
      bus.req = 3'b111;
      wait_launch(0);
      grant_cycle(0, 5, 1'b0);
      wait_launch(1);
      grant_cycle(1, 5, 1'b0);
      wait_launch(2);
      grant_cycle(2, 5, 1'b0);
      wait_launch(0);
      bus.req = '0;
      grant_cycle(0, 5, 1'b0);

      // isolation: engine 1 owns, others toggle paint/done randomly
      bus.req = 3'b010;
      wait_launch(1);
      bus.req = '0;
      grant_cycle(1, 8, 1'b0);

      // timeout on engine 2, then engine 0 is next; then done/timeout race
      bus.req = 3'b101;
      wait_launch(2);
      bus.req = 3'b001;
      grant_cycle(2, -1, 1'b0);
      wait_launch(0);
      bus.req = '0;
      grant_cycle(0, TMO, 1'b0);

      // randomized rounds against the pick model
      for (int r = 0; r < 14; r++) begin
         rq = NR'($urandom_range(1, 7));
         bus.req = rq;
         e = model_pick(rq, ptr_m);
         wait_launch(e);
         if ($urandom_range(0, 1) == 0) bus.req[e] = 1'b0;
         da = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO));
         grant_cycle(e, da, 1'b0);
      end

      // async reset in the middle of RUN
      bus.req = 3'b001;
      wait_launch(0);
      bus.req = '0;
      bus.paint_i = 3'b001;
      step();
      step();
      chk("pre_rst_fb_we", bus.fb_we, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_grant", bus.grant, 0);
      chk("arst_init", bus.init_o, 0);
      chk("arst_fb_we", bus.fb_we, 0);
      chk("arst_busy", bus.busy, 0);
      #2;
      rst = 1'b0;
      bus.paint_i = '0;
      ptr_m = 0;
      bus.req = 3'b110;
      wait_launch(model_pick(3'b110, ptr_m));
      chk("post_rst_first", bus.grant, 3'b010);
      bus.req = '0;
      grant_cycle(1, 2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
